// File: rtl/bongo_pkg.sv
// Shared drum codes and arbiter FSM state for the bongo voice path.
// Optional build macro BONGO_LOCKOUT_EN enables per-drum retrigger lockout.
package bongo_pkg;

    localparam logic DRUM_LEFT  = 1'b0;
    localparam logic DRUM_RIGHT = 1'b1;

    localparam logic [1:0] HIT_NONE  = 2'b00;
    localparam logic [1:0] HIT_LEFT  = 2'b01;
    localparam logic [1:0] HIT_RIGHT = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        PLAY  = 2'd2
    } state_t;

endpackage

// File: rtl/bongo_holdoff.sv
// Per-drum rising-edge detector with optional lockout counter.
// Lockout is compiled in only when BONGO_LOCKOUT_EN is defined.
module bongo_holdoff #(
    parameter int HOLDOFF_W      = 16,
    parameter int HOLDOFF_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic hit,
    output logic accept
);
    logic prev;
    logic new_hit;

    if (longint'(HOLDOFF_CYCLES) >= (64'd1 << HOLDOFF_W)) begin : g_bad_cfg
        $error("HOLDOFF_CYCLES does not fit in HOLDOFF_W bits");
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= 1'b0;
        else     prev <= hit;
    end

    assign new_hit = hit & ~prev;

`ifdef BONGO_LOCKOUT_EN
    logic [HOLDOFF_W-1:0] cnt;

    // Edges during an active lockout vanish without a trace.
    assign accept = new_hit & (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              cnt <= '0;
        else if (accept)      cnt <= HOLDOFF_W'(HOLDOFF_CYCLES);
        else if (cnt != '0)   cnt <= cnt - 1'b1;
    end
`else
    assign accept = new_hit;
`endif

endmodule

// File: rtl/bongo_voice_arbiter.sv
// Arbitrates left/right bongo hits onto a single sample voice.
// Build macro BONGO_LOCKOUT_EN adds per-drum retrigger lockout.
module bongo_voice_arbiter
    import bongo_pkg::*;
#(
    parameter int HOLDOFF_W      = 16,
    parameter int HOLDOFF_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] bongo_hit,
    input  logic       voice_done,
    output logic       voice_start,
    output logic       voice_sel,
    output logic       busy,
    output logic       dropped
);
    state_t     state;
    logic [1:0] accept;
    logic [1:0] pending;
    logic [1:0] clear_mask;
    logic [1:0] pending_nxt;
    logic       last_sel;
    logic       pick;

    bongo_holdoff #(
        .HOLDOFF_W      (HOLDOFF_W),
        .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
    ) u_left (
        .clk    (clk),
        .rst    (rst),
        .hit    (bongo_hit[DRUM_LEFT]),
        .accept (accept[DRUM_LEFT])
    );

    bongo_holdoff #(
        .HOLDOFF_W      (HOLDOFF_W),
        .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
    ) u_right (
        .clk    (clk),
        .rst    (rst),
        .hit    (bongo_hit[DRUM_RIGHT]),
        .accept (accept[DRUM_RIGHT])
    );

    always_comb begin
        clear_mask = 2'b00;
        if (state == START) clear_mask[voice_sel] = 1'b1;
    end

    // A fresh hit on the drum being cleared wins and stays pending.
    assign pending_nxt = (pending & ~clear_mask) | accept;

    always_comb begin
        pick = DRUM_LEFT;
        priority case (1'b1)
            &pending:            pick = ~last_sel;
            pending[DRUM_RIGHT]: pick = DRUM_RIGHT;
            default:             pick = DRUM_LEFT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pending     <= 2'b00;
            last_sel    <= DRUM_RIGHT;
            voice_start <= 1'b0;
            voice_sel   <= DRUM_LEFT;
            busy        <= 1'b0;
            dropped     <= 1'b0;
        end else begin
            pending     <= pending_nxt;
            dropped     <= |(accept & pending & ~clear_mask);
            voice_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|pending) begin
                        state       <= START;
                        voice_start <= 1'b1;
                        voice_sel   <= pick;
                        last_sel    <= pick;
                        busy        <= 1'b1;
                    end
                end
                START: begin
                    state <= PLAY;
                end
                PLAY: begin
                    if (voice_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
